axis_fifo_drain: RTL and testbench

Drains a show-ahead FIFO (data valid whenever `fifo_val` is high; `fifo_read` pops it) and emits its contents as AXI4-Stream packets of a run-time length. The last beat of each packet carries `m_tlast`. Sits directly downstream of the FIFO buffer in the AXI4 datapath. A single registered output stage gives full throughput and keeps the AXI-Stream outputs glitch-free.

---
 rtl/axis_fifo_drain_pkg.sv | 13 +
 rtl/axis_beat_reg.sv | 35 +++
 rtl/axis_fifo_drain.sv | 112 +++++++++++
 tb/tb_axis_fifo_drain.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_drain_pkg.sv
// Shared definitions for the FIFO-to-AXI-Stream packet drainer:
// FSM state encoding and the default data / length field widths.
package axis_fifo_drain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 8;

endpackage

// File: rtl/axis_beat_reg.sv
// Single-entry AXI-Stream output register. A load captures a new beat and
// raises tvalid; without a load, an accepting sink (ready) empties the entry.
module axis_beat_reg
    import axis_fifo_drain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast
);

    // Capture a beat on load, otherwise drop valid/last once the sink accepts
    always_ff @(posedge clk) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (ready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_fifo_drain.sv
// Drains a show-ahead FIFO into AXI-Stream packets of a run-time length.
// A packet is requested with start/pkt_len; the last beat carries m_tlast and
// done pulses once that beat is accepted.
// Optional feature: define AXIS_FIFO_DRAIN_PKT_CNT_EN to add a 32-bit
// completed-packet counter output pkt_cnt.
module axis_fifo_drain
    import axis_fifo_drain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              done,
    input  logic              fifo_val,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
    ,
    output logic [31:0]       pkt_cnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_next;
    logic             done_next;
    logic             load;
    logic             beat_last;

    // Next-state, remaining-count and load decisions; the output register is
    // only refilled when it is empty or its beat is being accepted this cycle
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        done_next      = 1'b0;
        load           = 1'b0;
        beat_last      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (pkt_len != '0)) begin
                    state_next     = RUN;
                    remaining_next = pkt_len;
                end
            end
            RUN: begin
                load = fifo_val && (remaining != '0) && (!m_tvalid || m_tready);
                if (load) begin
                    remaining_next = remaining - LEN_W'(1);
                    beat_last      = (remaining == LEN_W'(1));
                end
                if (m_tvalid && m_tready && m_tlast) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, remaining beat count and the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            done      <= done_next;
        end
    end

`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
    // Completed-packet counter, stepping on the same edge that raises done
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if (done_next) begin
            pkt_cnt <= pkt_cnt + 32'd1;
        end
    end
`endif

    assign fifo_read = load;
    assign busy      = (state == RUN);

    axis_beat_reg #(
        .DATA_W(DATA_W)
    ) u_beat_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .ready     (m_tready),
        .load_data (fifo_data),
        .load_last (beat_last),
        .tvalid    (m_tvalid),
        .tdata     (m_tdata),
        .tlast     (m_tlast)
    );

endmodule

// File: tb/tb_axis_fifo_drain.sv
// Self-checking bench for axis_fifo_drain. A queue models the show-ahead FIFO;
// every popped word is paired with its expected tlast (from the packet plan
// made at start time) and pushed to a scoreboard that is compared on each
// stream handshake. Define AXIS_FIFO_DRAIN_PKT_CNT_EN to also check pkt_cnt.
module tb_axis_fifo_drain;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pkt_len;
    logic       busy;
    logic       done;
    logic       fifo_val;
    logic [7:0] fifo_data;
    logic       fifo_read;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
    logic [31:0] pkt_cnt;
    int          pkt_model;
`endif

    logic [7:0] fifo_q[$];
    logic       last_plan[$];
    logic [8:0] exp_q[$];

    int   pass_count;
    int   check_count;
    int   cycle;
    int   hs_count;
    int   first_read_cycle;
    int   first_hs_cycle;
    int   last_hs_cycle;
    logic model_run;
    logic done_exp;
    logic stalled;
    logic [7:0] stall_data;
    logic stall_last;

    axis_fifo_drain dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pkt_len   (pkt_len),
        .busy      (busy),
        .done      (done),
        .fifo_val  (fifo_val),
        .fifo_data (fifo_data),
        .fifo_read (fifo_read),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast)
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    task automatic refreshFifo();
        fifo_val  = (fifo_q.size() != 0);
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic pushWord(input logic [7:0] w);
        fifo_q.push_back(w);
        refreshFifo();
    endtask

    // One clock cycle: check outputs mid-cycle, update the model, then apply
    // the FIFO pop just after the rising edge.
    task automatic tick();
        logic       hs;
        logic       pop_now;
        logic       done_next;
        logic [7:0] w;
        logic [8:0] e;
        @(negedge clk);
        checkOutput("busy", busy, model_run);
        checkOutput("done", done, done_exp);
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        checkOutput("pkt_cnt", pkt_cnt, pkt_model);
`endif
        if (!model_run) checkOutput("read_idle", fifo_read, 0);
        if (m_tvalid && !m_tready) checkOutput("read_stall", fifo_read, 0);
        if (stalled && m_tvalid) begin
            checkOutput("stall_data", m_tdata, stall_data);
            checkOutput("stall_last", m_tlast, stall_last);
        end
        hs = m_tvalid && m_tready && !reset;
        if (hs) begin
            checkOutput("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("beat_data", m_tdata, e[7:0]);
                checkOutput("beat_last", m_tlast, e[8]);
            end
            if (first_hs_cycle < 0) first_hs_cycle = cycle;
            last_hs_cycle = cycle;
            hs_count++;
        end
        stalled    = m_tvalid && !m_tready;
        stall_data = m_tdata;
        stall_last = m_tlast;
        pop_now    = fifo_read;
        if (pop_now && first_read_cycle < 0) first_read_cycle = cycle;
        done_next = hs && m_tlast;
        if (reset) begin
            model_run = 1'b0;
        end else if (!model_run && start && pkt_len != 8'd0) begin
            model_run = 1'b1;
            for (int i = 1; i <= int'(pkt_len); i++) last_plan.push_back(i == int'(pkt_len));
        end else if (model_run && done_next) begin
            model_run = 1'b0;
        end
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        if (reset) pkt_model = 0;
        else if (done_next) pkt_model++;
`endif
        @(posedge clk);
        #1;
        if (pop_now) begin
            checkOutput("pop_nonempty", fifo_q.size() != 0, 1);
            checkOutput("pop_planned", last_plan.size() != 0, 1);
            if (fifo_q.size() != 0 && last_plan.size() != 0) begin
                w = fifo_q.pop_front();
                exp_q.push_back({last_plan.pop_front(), w});
            end
        end
        if (reset) begin
            last_plan.delete();
            exp_q.delete();
            stalled  = 1'b0;
            done_exp = 1'b0;
        end else begin
            done_exp = done_next;
        end
        refreshFifo();
        cycle++;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] len, input logic rdy);
        start    = s;
        pkt_len  = len;
        m_tready = rdy;
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((model_run || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("timeout", n < budget, 1);
        tick();
    endtask

    task automatic clearMarks();
        first_read_cycle = -1;
        first_hs_cycle   = -1;
        last_hs_cycle    = -1;
        hs_count         = 0;
    endtask

    initial begin
        int start_cycle;
        int n;
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        int cnt_before;
`endif
        pass_count  = 0;
        check_count = 0;
        cycle       = 0;
        model_run   = 1'b0;
        done_exp    = 1'b0;
        stalled     = 1'b0;
        stall_data  = 8'h00;
        stall_last  = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        pkt_len     = 8'd0;
        m_tready    = 1'b0;
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        pkt_model   = 0;
`endif
        clearMarks();
        refreshFifo();

        $display("[TB] reset");
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_tvalid", m_tvalid, 0);
        checkOutput("rst_tlast", m_tlast, 0);
        checkOutput("rst_tdata", m_tdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_read", fifo_read, 0);

        $display("[TB] basic packet");
        pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
        clearMarks();
        start_cycle = cycle;
        applyStimulus(1'b1, 8'd4, 1'b1);
        waitIdle(40);
        checkOutput("first_read_lat", first_read_cycle - start_cycle, 1);
        checkOutput("first_beat_lat", first_hs_cycle - start_cycle, 2);
        checkOutput("throughput", last_hs_cycle - first_hs_cycle, 3);
        checkOutput("basic_beats", hs_count, 4);

        $display("[TB] backpressure");
        pushWord(8'hA1); pushWord(8'hA2); pushWord(8'hA3);
        clearMarks();
        applyStimulus(1'b1, 8'd3, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("bp_valid", m_tvalid, 1);
        checkOutput("bp_fifo_kept", fifo_q.size(), 2);
        m_tready = 1'b1;
        waitIdle(40);
        checkOutput("bp_beats", hs_count, 3);

        $display("[TB] fifo underrun");
        pushWord(8'hB1); pushWord(8'hB2);
        clearMarks();
        applyStimulus(1'b1, 8'd4, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("ur_beats", hs_count, 2);
        checkOutput("ur_tvalid", m_tvalid, 0);
        checkOutput("ur_busy", busy, 1);
        pushWord(8'hB3); pushWord(8'hB4);
        waitIdle(40);
        checkOutput("ur_total", hs_count, 4);

        $display("[TB] ignored starts");
        applyStimulus(1'b1, 8'd0, 1'b1);
        tick();
        checkOutput("zero_len_busy", busy, 0);
        pushWord(8'hC1); pushWord(8'hC2); pushWord(8'hC3);
        clearMarks();
        applyStimulus(1'b1, 8'd2, 1'b1);
        applyStimulus(1'b1, 8'd9, 1'b1);
        waitIdle(40);
        checkOutput("ign_beats", hs_count, 2);
        checkOutput("ign_fifo_left", fifo_q.size(), 1);

        $display("[TB] single beat and back-to-back");
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        cnt_before = pkt_model;
`endif
        pushWord(8'hD1);
        clearMarks();
        applyStimulus(1'b1, 8'd1, 1'b1);
        n = 0;
        while (!done_exp && n < 20) begin
            tick();
            n++;
        end
        checkOutput("b2b_done_seen", done_exp, 1);
        applyStimulus(1'b1, 8'd1, 1'b1);
        waitIdle(40);
        checkOutput("b2b_beats", hs_count, 2);
`ifdef AXIS_FIFO_DRAIN_PKT_CNT_EN
        checkOutput("b2b_pkt_cnt_delta", pkt_cnt - cnt_before, 2);
`endif

        $display("[TB] reset mid-packet");
        pushWord(8'hE1); pushWord(8'hE2); pushWord(8'hE3);
        pushWord(8'hE4); pushWord(8'hE5); pushWord(8'hF1);
        clearMarks();
        applyStimulus(1'b1, 8'd5, 1'b1);
        n = 0;
        while (hs_count < 2 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("rm_two_beats", hs_count, 2);
        reset    = 1'b1;
        m_tready = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("rm_tvalid", m_tvalid, 0);
        checkOutput("rm_tlast", m_tlast, 0);
        checkOutput("rm_tdata", m_tdata, 0);
        checkOutput("rm_busy", busy, 0);
        checkOutput("rm_done", done, 0);
        checkOutput("rm_read", fifo_read, 0);
        clearMarks();
        applyStimulus(1'b1, 8'd1, 1'b1);
        waitIdle(40);
        checkOutput("rm_new_beats", hs_count, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
